// File: rtl/aes_key_sched.sv
// AES-128 style round-key generator. The cipher key is loaded a byte at a time.
// Each round key is expanded in place in one 16-byte register, using an
// external S-box with configurable read latency. Every key is then streamed
// out byte-serially when the consumer asks for it.
module aes_key_sched #(
  parameter int NR        = 10,
  parameter int SBOX_LAT  = 1,
  parameter int EMIT_KEY0 = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       enable_din,
  output logic [7:0] sbox_addr,
  output logic       enable_sbox,
  input  logic [7:0] sbox_in,
  input  logic       round_complete,
  output logic [7:0] dout,
  output logic       enable_out,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD, S_SUB_ISSUE, S_SUB_WAIT, S_EXPAND, S_HOLD, S_OUT
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t              r_state, w_state_next;
  logic [3:0]          r_cnt;          // byte index / issue slot / column / out byte
  logic [1:0]          r_cap_cnt;      // which S-box result arrives next
  logic [SBOX_LAT-1:0] r_strobe_pipe;  // strobe delayed to line up with sbox_in
  logic [7:0]          r_key [16];     // row-major: byte i = row i/4, column i%4
  logic [7:0]          r_sw [4];       // SubWord(RotWord(column 3)), row 0 first
  logic [7:0]          r_rcon;
  logic [3:0]          r_round;
  logic                r_pending;
  logic                r_done;
  logic                w_capture;
  logic [1:0]          w_col;
  logic [7:0]          w_mix [4];
  logic [7:0]          w_col_new [4];

  assign w_col     = r_cnt[1:0];
  assign w_capture = r_strobe_pipe[SBOX_LAT-1];
  assign round_idx = r_round;
  assign done      = r_done;

  // Per-row mixing term: column 0 takes the substituted word (plus Rcon on
  // row 0); later columns take the column just rewritten on the previous cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam logic [7:0] RCON_MASK = (gi == 0) ? 8'hff : 8'h00;
      assign w_mix[gi] = (w_col == 2'd0) ? (r_sw[gi] ^ (r_rcon & RCON_MASK))
                                         : r_key[{2'(gi), w_col - 2'd1}];
      assign w_col_new[gi] = r_key[{2'(gi), w_col}] ^ w_mix[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_next;
  end

  // Next-state decode and all strobes; outputs are zero outside their states.
  always_comb begin
    w_state_next = r_state;
    enable_sbox  = 1'b0;
    enable_out   = 1'b0;
    sbox_addr    = 8'h00;
    dout         = 8'h00;
    busy         = (r_state != S_LOAD);
    case (r_state)
      S_LOAD: begin
        if (enable_din && r_cnt == 4'd15)
          w_state_next = (EMIT_KEY0 != 0) ? S_HOLD : S_SUB_ISSUE;
      end
      S_SUB_ISSUE: begin
        enable_sbox = 1'b1;
        // Rotated column 3: bytes 7, 11, 15, 3.
        sbox_addr = r_key[{w_col + 2'd1, 2'd3}];
        if (w_col == 2'd3) w_state_next = S_SUB_WAIT;
      end
      S_SUB_WAIT: begin
        if (w_capture && r_cap_cnt == 2'd3) w_state_next = S_EXPAND;
      end
      S_EXPAND: begin
        if (w_col == 2'd3) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_pending) w_state_next = S_OUT;
      end
      S_OUT: begin
        enable_out = 1'b1;
        dout       = r_key[r_cnt];
        if (r_cnt == 4'd15)
          w_state_next = (r_round < NR_L) ? S_SUB_ISSUE : S_LOAD;
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  // Shared step counter: restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_state_next != r_state) begin
      r_cnt <= 4'd0;
    end else if ((r_state == S_LOAD && enable_din) || r_state == S_SUB_ISSUE ||
                 r_state == S_EXPAND || r_state == S_OUT) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Strobe delay line; its tail marks the cycle in which sbox_in is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe_pipe <= '0;
      r_cap_cnt     <= 2'd0;
    end else begin
      for (int k = SBOX_LAT - 1; k > 0; k--) r_strobe_pipe[k] <= r_strobe_pipe[k-1];
      r_strobe_pipe[0] <= enable_sbox;
      if (w_capture) r_cap_cnt <= r_cap_cnt + 2'd1;
    end
  end

  // Key and S-box word storage (no reset: always reloaded before use).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_LOAD && enable_din) begin
        r_key[r_cnt] <= din;
      end else if (r_state == S_EXPAND) begin
        for (int k = 0; k < 4; k++) r_key[{2'(k), w_col}] <= w_col_new[k];
      end
      if (w_capture) r_sw[r_cap_cnt] <= sbox_in;
    end
  end

  // Round bookkeeping: Rcon, round index, request flag and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcon    <= 8'h01;
      r_round   <= 4'd0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_HOLD && r_pending)
        r_pending <= 1'b0;
      else if (round_complete && r_state != S_LOAD)
        r_pending <= 1'b1;
      if (r_state == S_LOAD && w_state_next != S_LOAD)
        r_round <= (EMIT_KEY0 != 0) ? 4'd0 : 4'd1;
      if (r_state == S_EXPAND && w_col == 2'd3)
        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      if (r_state == S_OUT && r_cnt == 4'd15) begin
        if (r_round < NR_L) begin
          r_round <= r_round + 4'd1;
        end else begin
          r_done    <= 1'b1;
          r_round   <= 4'd0;
          r_rcon    <= 8'h01;
          r_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: three instances (S-box latency 1, 3, and 2 with
// key 0 emitted), a behavioural S-box, and a FIPS-197 word-based key-expansion model.
module tb_aes_key_sched;

  localparam int NI = 3;
  localparam int NR = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst, en_din, rc, en_sbox, en_out, busy, done;
  logic [7:0]    din [NI];
  logic [7:0]    sbox_addr [NI];
  logic [7:0]    sbox_in [NI];
  logic [7:0]    dout [NI];
  logic [3:0]    ridx [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 1) ? 3 : ((gi == 2) ? 2 : 1);
      localparam int E = (gi == 2) ? 1 : 0;
      aes_key_sched #(.NR(NR), .SBOX_LAT(L), .EMIT_KEY0(E)) u_dut (
        .clk(clk), .rst(rst[gi]), .din(din[gi]), .enable_din(en_din[gi]),
        .sbox_addr(sbox_addr[gi]), .enable_sbox(en_sbox[gi]), .sbox_in(sbox_in[gi]),
        .round_complete(rc[gi]), .dout(dout[gi]), .enable_out(en_out[gi]),
        .round_idx(ridx[gi]), .busy(busy[gi]), .done(done[gi]));
    end
  endgenerate

  function automatic int lat_of(int i);
    return (i == 1) ? 3 : ((i == 2) ? 2 : 1);
  endfunction

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  logic [7:0] sbox_tab [256];
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // External S-box: result valid exactly SBOX_LAT cycles after the strobe,
  // random junk in every other cycle.
  logic [7:0] rd_pipe [NI][4];
  logic       rv_pipe [NI][4];
  logic [7:0] junk [NI];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int k = 3; k > 0; k--) begin
        rd_pipe[i][k] <= rd_pipe[i][k-1];
        rv_pipe[i][k] <= rv_pipe[i][k-1];
      end
      rd_pipe[i][0] <= sbox_tab[sbox_addr[i]];
      rv_pipe[i][0] <= (en_sbox[i] === 1'b1);
      junk[i]       <= 8'($urandom);
    end
  end
  always_comb begin
    for (int i = 0; i < NI; i++)
      sbox_in[i] = rv_pipe[i][lat_of(i)-1] ? rd_pipe[i][lat_of(i)-1] : junk[i];
  end

  // Output monitor.
  typedef struct { int inst; int idx; logic [7:0] b; int c; } ob_t;
  ob_t q_out[$];
  int  n_strobe [NI];
  int  n_done [NI];
  int  n_overlap;
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (en_out[i] === 1'b1) q_out.push_back('{i, int'(ridx[i]), dout[i], cyc});
      if (en_sbox[i] === 1'b1) n_strobe[i]++;
      if (done[i] === 1'b1) n_done[i]++;
      if (en_sbox[i] === 1'b1 && en_out[i] === 1'b1) n_overlap++;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] kb [16];
  logic [7:0] exp_b [11][16];
  int load_cyc;

  // Key expansion in FIPS-197 word form; round r byte j = row j/4 of word 4r+j%4.
  task automatic model_expand();
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int c = 0; c < 4; c++) w[c] = {kb[c], kb[c+4], kb[c+8], kb[c+12]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t ^= {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int j = 0; j < 16; j++) exp_b[r][j] = 8'(w[4*r + j%4] >> (24 - 8*(j/4)));
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) kb[c + 4*r] = k[127 - 32*c - 8*r -: 8];
  endtask

  task automatic random_key();
    for (int j = 0; j < 16; j++) kb[j] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = '1; en_din = '0; rc = '0;
    repeat (2) @(negedge clk);
    rst = '0;
  endtask

  // Feed kb bytes 0..15 with random idle gaps; returns at the negedge after byte 15.
  task automatic load_key(input int inst);
    for (int b = 0; b < 16; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        en_din[inst] = 1'b0; din[inst] = 8'($urandom);
        @(negedge clk);
      end
      en_din[inst] = 1'b1; din[inst] = kb[b];
      @(negedge clk);
    end
    en_din[inst] = 1'b0;
    load_cyc = cyc - 1;
  endtask

  // Random round_complete pulses (first one immediately) and junk key bytes
  // while busy, until done or the cycle budget runs out.
  task automatic run_rounds(input int inst, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rc[inst]     = (n == 0) || ($urandom_range(0, 3) == 0);
      en_din[inst] = busy[inst] ? 1'($urandom) : 1'b0;
      din[inst]    = 8'($urandom);
      @(negedge clk);
      if (done[inst] === 1'b1) begin timed_out = 1'b0; break; end
    end
    rc[inst] = 1'b0; en_din[inst] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Full schedule on one instance against the model.
  task automatic test_expansion(input int inst, input string tag);
    bit to;
    int first_r = (inst == 2) ? 0 : 1;
    int nb = (NR + 1 - first_r) * 16;
    model_expand();
    q_out.delete(); n_strobe[inst] = 0; n_done[inst] = 0; n_overlap = 0;
    load_key(inst);
    run_rounds(inst, to);
    n_assert++;
    if (to) begin n_fail++; $display("FAIL %s done_timeout: no done within 3000 cycles", tag); end
    n_assert++;
    if (q_out.size() != nb) begin
      n_fail++; $display("FAIL %s out_count: got %0d bytes, expected %0d", tag, q_out.size(), nb);
    end
    for (int k = 0; k < q_out.size() && k < nb; k++) begin
      int r = k / 16 + first_r;
      int j = k % 16;
      n_assert++;
      if (q_out[k].inst != inst || q_out[k].idx != r || q_out[k].b !== exp_b[r][j] ||
          (j != 0 && q_out[k].c != q_out[k-1].c + 1)) begin
        n_fail++;
        $display("FAIL %s key_byte r%0d b%0d: got inst%0d idx%0d %h @%0d, expected inst%0d idx%0d %h",
                 tag, r, j, q_out[k].inst, q_out[k].idx, q_out[k].b, q_out[k].c, inst, r, exp_b[r][j]);
      end
    end
    if (inst != 2 && q_out.size() > 0) begin
      n_assert++;
      if (q_out[0].c - load_cyc != 10 + lat_of(inst)) begin
        n_fail++;
        $display("FAIL %s latency: got %0d cycles, expected %0d", tag, q_out[0].c - load_cyc, 10 + lat_of(inst));
      end
    end
    n_assert++;
    if (n_done[inst] != 1 || busy[inst] !== 1'b0) begin
      n_fail++; $display("FAIL %s done_pulse: got %0d done cycles busy=%b, expected 1 and 0", tag, n_done[inst], busy[inst]);
    end
    n_assert++;
    if (n_strobe[inst] != 4 * NR || n_overlap != 0) begin
      n_fail++;
      $display("FAIL %s sbox_strobes: got %0d strobes %0d overlaps, expected %0d and 0", tag, n_strobe[inst], n_overlap, 4 * NR);
    end
    $display("%s: key schedule on instance %0d, %0d bytes observed", tag, inst, q_out.size());
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      logic [27:0] got = {en_sbox[i], en_out[i], busy[i], done[i], dout[i], sbox_addr[i], ridx[i]};
      n_assert++;
      if (got !== 28'h0) begin n_fail++; $display("FAIL reset_outputs inst%0d: got %h, expected 0", i, got); end
    end
    $display("reset: outputs of all instances checked");
  endtask

  task automatic test_fips_a1();
    logic [127:0] r1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    logic [127:0] r10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    do_reset();
    set_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    test_expansion(0, "fips_a1");
    if (q_out.size() >= 160) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] g1  = {q_out[c].b, q_out[c+4].b, q_out[c+8].b, q_out[c+12].b};
        logic [31:0] g10 = {q_out[144+c].b, q_out[148+c].b, q_out[152+c].b, q_out[156+c].b};
        n_assert++;
        if (g1 !== r1[127-32*c -: 32] || g10 !== r10[127-32*c -: 32]) begin
          n_fail++;
          $display("FAIL fips_a1_words w%0d: got %h/%h, expected %h/%h", c, g1, g10, r1[127-32*c -: 32], r10[127-32*c -: 32]);
        end
      end
    end
  endtask

  task automatic test_zero_key();
    logic [127:0] r2 = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    do_reset();
    set_key(128'h0);
    test_expansion(0, "zero_key");
    if (q_out.size() >= 32) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] g1 = {q_out[c].b, q_out[c+4].b, q_out[c+8].b, q_out[c+12].b};
        logic [31:0] g2 = {q_out[16+c].b, q_out[20+c].b, q_out[24+c].b, q_out[28+c].b};
        n_assert++;
        if (g1 !== 32'h62636363 || g2 !== r2[127-32*c -: 32]) begin
          n_fail++;
          $display("FAIL zero_key_words w%0d: got %h/%h, expected 62636363/%h", c, g1, g2, r2[127-32*c -: 32]);
        end
      end
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 3; n++) begin
      do_reset();
      random_key();
      test_expansion(0, "random_key");
    end
  endtask

  task automatic test_sbox_lat3();
    do_reset();
    set_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    test_expansion(1, "sbox_lat3_a1");
    random_key();
    test_expansion(1, "sbox_lat3_rand");
  endtask

  task automatic test_emit_key0();
    do_reset();
    random_key();
    test_expansion(2, "emit_key0");
  endtask

  task automatic test_reset_mid_out();
    int seen = 0;
    int skip = $urandom_range(1, 12);
    bit found = 1'b0;
    do_reset();
    random_key();
    load_key(0);
    for (int n = 0; n < 3000 && !found; n++) begin
      rc[0] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (en_out[0] === 1'b1 && ridx[0] == 4'd4) begin
        seen++;
        if (seen == skip) found = 1'b1;
      end
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL reset_mid_out_reach: round 4 output not reached"); end
    rc[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({en_out[0], busy[0], en_sbox[0], ridx[0], dout[0]} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_mid_out_abort: got en_out=%b busy=%b en_sbox=%b idx=%0d dout=%h, expected all 0",
               en_out[0], busy[0], en_sbox[0], ridx[0], dout[0]);
    end
    rst[0] = 1'b0;
    @(negedge clk);
    set_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    test_expansion(0, "reload_after_reset");
  endtask

  task automatic test_pending_once();
    do_reset();
    random_key();
    model_expand();
    q_out.delete(); n_strobe[0] = 0;
    load_key(0);
    repeat (5) @(negedge clk);
    rc[0] = 1'b1;
    repeat (3) @(negedge clk);
    rc[0] = 1'b0;
    repeat (80) @(negedge clk);
    n_assert++;
    if (q_out.size() != 16 || en_out[0] !== 1'b0 || busy[0] !== 1'b1 || n_strobe[0] != 8) begin
      n_fail++;
      $display("FAIL pending_once: got %0d bytes en_out=%b busy=%b strobes=%0d, expected 16 0 1 8",
               q_out.size(), en_out[0], busy[0], n_strobe[0]);
    end
    for (int k = 0; k < q_out.size() && k < 16; k++) begin
      n_assert++;
      if (q_out[k].idx != 1 || q_out[k].b !== exp_b[1][k]) begin
        n_fail++;
        $display("FAIL pending_once_byte b%0d: got idx%0d %h, expected idx1 %h", k, q_out[k].idx, q_out[k].b, exp_b[1][k]);
      end
    end
    $display("pending_once: %0d bytes after three requests during expansion", q_out.size());
    do_reset();
  endtask

  initial begin
    rst = '1; en_din = '0; rc = '0;
    for (int i = 0; i < NI; i++) din[i] = 8'h00;
    build_sbox();
    test_reset();
    test_fips_a1();
    test_zero_key();
    test_random_keys();
    test_sbox_lat3();
    test_emit_key0();
    test_reset_mid_out();
    test_pending_once();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of round keys generated (1..14).
REQ-002 SHALL have parameter SBOX_LAT, default 1, meaning external S-box read latency in cycles (1..4).
REQ-003 SHALL have parameter EMIT_KEY0, default 0; when 1, the cipher key is emitted as round key 0 before round 1.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 din  in  8  key byte input.
REQ-007 enable_din  in  1  din valid qualifier.
REQ-008 sbox_addr  out  8  S-box lookup address.
REQ-009 enable_sbox  out  1  S-box read strobe, one lookup per high cycle.
REQ-010 sbox_in  in  8  S-box result, valid SBOX_LAT cycles after its strobe.
REQ-011 round_complete  in  1  request pulse for the next round key.
REQ-012 dout  out  8  round-key byte output.
REQ-013 enable_out  out  1  dout valid qualifier.
REQ-014 round_idx  out  4  index of the key currently being emitted.
REQ-015 busy  out  1  high in every state except LOAD.
REQ-016 done  out  1  one-cycle pulse after the last byte of round key NR.

Function
REQ-017 Byte layout SHALL be row-major: byte i = row i/4, column i%4; column 3 = bytes 3,7,11,15.
REQ-018 LOAD: each cycle with enable_din=1 SHALL store din at index 0..15 in order; after byte 15, go to SUB_ISSUE next cycle (or to HOLD with round_idx=0 if EMIT_KEY0=1).
REQ-019 enable_din outside LOAD SHALL be ignored.
REQ-020 SUB_ISSUE: 4 consecutive cycles, enable_sbox=1 and sbox_addr = RotWord(column 3) = bytes 7,11,15,3 in that order.
REQ-021 SUB_WAIT: sbox_in SHALL be captured exactly SBOX_LAT cycles after each strobe; the state ends on the cycle after the 4th capture.
REQ-022 EXPAND: 4 cycles, one column per cycle, column 0 first: c0 = k.c0 ^ S ^ {Rcon,00,00,00}; cj = k.cj ^ new c(j-1).
REQ-023 Rcon SHALL start at 01 for round 1 and advance by GF(2^8) xtime (poly 11B), giving 01,02,04,08,10,20,40,80,1B,36,6C,D8,AB,4D.
REQ-024 After EXPAND, the key register SHALL hold the new round key (on-the-fly, single 128-bit store); go to HOLD.
REQ-025 A round_complete pulse in any non-LOAD state SHALL set a pending flag; HOLD proceeds to OUT on the cycle after pending=1, clearing it; multiple pulses before HOLD count as one.
REQ-026 OUT: 16 consecutive cycles, enable_out=1, dout = bytes 0..15; round_idx stable throughout.
REQ-027 After OUT: if round_idx<NR, increment round_idx and go to SUB_ISSUE; else pulse done, go to LOAD, round_idx=0.
REQ-028 Latency from byte-15 load to first possible enable_out SHALL be 4+SBOX_LAT+4+2 cycles (EMIT_KEY0=0, pending already set).
REQ-029 enable_sbox and enable_out SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 SHALL force state LOAD, byte counter 0, round_idx 0, Rcon 01, pending 0, and enable_sbox, enable_out, busy, done, dout, sbox_addr to 0, aborting any operation.
REQ-031 The key register contents need no reset value; they SHALL never be output before a full reload.

Verification
REQ-032 FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c fed row-major, NR=10 -> round 1 words a0fafe17 88542cb1 23a33939 2a6c7605, round 10 words d014f9a8 c9ee2589 e13f0cc8 b6630ca6, done pulse once.
REQ-033 All-zero key -> round 1 = 62636363 x4 words; round 2 = 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
REQ-034 SBOX_LAT=3 with the A.1 key -> identical keys; enable_sbox high exactly 4 cycles per round.
REQ-035 EMIT_KEY0=1 -> first burst equals the loaded key with round_idx=0, then 10 expanded keys.
REQ-036 rst asserted during OUT of round 4 -> enable_out=0 the next cycle; reload of the A.1 key reproduces round 1 correctly.
REQ-037 round_complete pulsed 3 times during EXPAND -> exactly one OUT burst, then HOLD waits.
